falafel_rsp_packer: RTL and testbench

Downstream stage of the allocator core. Takes one result per completed operation (alloc address or free acknowledgement) together with the originating message ID and packs it into the client response protocol: a header beat, plus a data beat for allocations. It buffers up to `NUM_ENTRIES` results so the core never stalls on a slow response consumer.

---
 rtl/falafel_pkg.sv | 21 ++
 rtl/falafel_sync_fifo.sv | 74 +++++++
 rtl/falafel_rsp_packer.sv | 140 ++++++++++++++
 tb/tb_falafel_rsp_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel response path.
package falafel_pkg;

  localparam int DATA_W      = 64;
  localparam int MSG_ID_W    = 8;
  localparam int NUM_ENTRIES = 4;

  typedef struct packed {
    logic [DATA_W-MSG_ID_W-3:0] reserved;
    logic                       fail;
    logic                       is_alloc;
    logic [MSG_ID_W-1:0]        id;
  } rsp_hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/falafel_sync_fifo.sv
// Synchronous FIFO whose read data is a register always holding the current head entry.
module falafel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_s;
  logic             push_s;
  logic             pop_s;

  // Next-state for pointers, count and the head register.
  always_comb begin
    push_s   = push_i && (count_r != CW'(DEPTH));
    pop_s    = pop_i && (count_r != {CW{1'b0}});
    count_s  = count_r + CW'(push_s) - CW'(pop_s);
    rd_ptr_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    // A write landing in an otherwise empty buffer becomes the head directly.
    if (push_s && ((count_r - CW'(pop_s)) == {CW{1'b0}})) begin
      head_s = wdata_i;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Storage array; contents need no reset since count gates their use.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // Pointers, count and head register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      head_r   <= head_s;
    end
  end

  assign rdata_o = head_r;
  assign full_o  = (count_r == CW'(DEPTH));
  assign empty_o = (count_r == {CW{1'b0}});
  assign count_o = count_r;

endmodule

// File: rtl/falafel_rsp_packer.sv
// Buffers allocator results and serialises them as header (+ data) response beats.
module falafel_rsp_packer #(
  parameter int MSG_ID_W    = falafel_pkg::MSG_ID_W,
  parameter int NUM_ENTRIES = falafel_pkg::NUM_ENTRIES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          res_val_i,
  output logic                          res_rdy_o,
  input  logic                          res_is_alloc_i,
  input  logic [MSG_ID_W-1:0]           res_id_i,
  input  logic [falafel_pkg::DATA_W-1:0] res_data_i,
  output logic                          rsp_val_o,
  input  logic                          rsp_rdy_i,
  output logic [falafel_pkg::DATA_W-1:0] rsp_data_o,
  output logic                          rsp_last_o,
  output logic [$clog2(NUM_ENTRIES):0]  occupancy_o
);

  import falafel_pkg::*;

  localparam int ENTRY_W = 1 + MSG_ID_W + DATA_W;
  localparam int CW      = $clog2(NUM_ENTRIES) + 1;

  rsp_state_e         state_r;
  rsp_state_e         state_s;
  logic               rdy_r;
  logic               push_s;
  logic               pop_s;
  logic               remain_s;
  logic [ENTRY_W-1:0] head_s;
  logic               head_alloc_s;
  logic [MSG_ID_W-1:0] head_id_s;
  logic [DATA_W-1:0]  head_data_s;
  logic [DATA_W-1:0]  hdr_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CW-1:0]      fifo_count_s;
  logic [CW-1:0]      occ_next_s;
  logic               rsp_val_s;
  logic [DATA_W-1:0]  rsp_data_s;
  logic               rsp_last_s;

  assign push_s = res_val_i && rdy_r && !fifo_full_s;

  falafel_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (NUM_ENTRIES)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .wdata_i ({res_is_alloc_i, res_id_i, res_data_i}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign head_alloc_s = head_s[ENTRY_W-1];
  assign head_id_s    = head_s[DATA_W +: MSG_ID_W];
  assign head_data_s  = head_s[DATA_W-1:0];

  // Header beat: id, is_alloc, fail (alloc returning address 0), zero above.
  always_comb begin
    hdr_s                 = {DATA_W{1'b0}};
    hdr_s[MSG_ID_W-1:0]   = head_id_s;
    hdr_s[MSG_ID_W]       = head_alloc_s;
    hdr_s[MSG_ID_W+1]     = head_alloc_s && (head_data_s == {DATA_W{1'b0}});
  end

  // Message FSM; outputs decode only registered state and the registered head.
  always_comb begin
    state_s    = state_r;
    pop_s      = 1'b0;
    rsp_val_s  = 1'b0;
    rsp_data_s = {DATA_W{1'b0}};
    rsp_last_s = 1'b0;
    // A same-cycle push keeps the stream going without a bubble.
    remain_s   = (fifo_count_s > CW'(1)) || push_s;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s || push_s) begin
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        rsp_val_s  = 1'b1;
        rsp_data_s = hdr_s;
        rsp_last_s = !head_alloc_s;
        if (rsp_rdy_i) begin
          if (head_alloc_s) begin
            state_s = DATA;
          end else begin
            pop_s   = 1'b1;
            state_s = remain_s ? HDR : IDLE;
          end
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        rsp_val_s  = 1'b1;
        rsp_data_s = head_data_s;
        rsp_last_s = 1'b1;
        if (rsp_rdy_i) begin
          pop_s   = 1'b1;
          state_s = remain_s ? HDR : IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    occ_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
  end

  // State register and ready flag; ready reflects start-of-cycle occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      rdy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      rdy_r   <= (occ_next_s < CW'(NUM_ENTRIES));
    end
  end

  assign res_rdy_o   = rdy_r;
  assign rsp_val_o   = rsp_val_s;
  assign rsp_data_o  = rsp_data_s;
  assign rsp_last_o  = rsp_last_s;
  assign occupancy_o = fifo_count_s;

endmodule

// File: tb/tb_falafel_rsp_packer.sv
// Directed and scoreboarded checks of falafel_rsp_packer with default parameters.
module tb_falafel_rsp_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        res_val_i;
  logic        res_rdy_o;
  logic        res_is_alloc_i;
  logic [7:0]  res_id_i;
  logic [63:0] res_data_i;
  logic        rsp_val_o;
  logic        rsp_rdy_i;
  logic [63:0] rsp_data_o;
  logic        rsp_last_o;
  logic [2:0]  occupancy_o;

  falafel_rsp_packer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .res_val_i      (res_val_i),
    .res_rdy_o      (res_rdy_o),
    .res_is_alloc_i (res_is_alloc_i),
    .res_id_i       (res_id_i),
    .res_data_i     (res_data_i),
    .rsp_val_o      (rsp_val_o),
    .rsp_rdy_i      (rsp_rdy_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_alloc;
    logic [7:0]  id;
    logic [63:0] addr;
    logic [63:0] exp_hdr;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  vec_t  vecs [5];
  beat_t exp_q [$];
  int    errors = 0;
  int    checks = 0;
  bit    rnd_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] model_hdr(input logic a, input logic [7:0] id, input logic [63:0] d);
    logic [63:0] r;
    r      = 64'd0;
    r[7:0] = id;
    r[8]   = a;
    r[9]   = a && (d == 64'd0);
    return r;
  endfunction

  // Scoreboard and stall-stability monitor, sampling on the falling edge.
  initial begin
    logic        stall_q;
    logic [63:0] stall_data;
    logic        stall_last;
    beat_t       b;
    stall_q = 1'b0;
    stall_data = 64'd0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("stall_val", {63'd0, rsp_val_o}, 64'd1);
          check("stall_data", rsp_data_o, stall_data);
          check("stall_last", {63'd0, rsp_last_o}, {63'd0, stall_last});
        end
        if (rsp_val_o && rsp_rdy_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%h, expected no beat", rsp_data_o);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", rsp_data_o, b.data);
            check("beat_last", {63'd0, rsp_last_o}, {63'd0, b.last});
          end
        end
        if (res_val_i && res_rdy_o) begin
          exp_q.push_back('{model_hdr(res_is_alloc_i, res_id_i, res_data_i), !res_is_alloc_i});
          if (res_is_alloc_i) begin
            exp_q.push_back('{res_data_i, 1'b1});
          end
        end
        stall_q    = rsp_val_o && !rsp_rdy_i;
        stall_data = rsp_data_o;
        stall_last = rsp_last_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic push_one(input logic a, input logic [7:0] id, input logic [63:0] d);
    res_val_i      = 1'b1;
    res_is_alloc_i = a;
    res_id_i       = id;
    res_data_i     = d;
    tick();
    res_val_i      = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    rsp_rdy_i = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || rsp_val_o) && w < 100) begin
      tick();
      w++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h05, 64'h0,                 64'h005, 64'h0};
    vecs[1] = '{1'b1, 8'h2A, 64'h1000,              64'h12A, 64'h1000};
    vecs[2] = '{1'b1, 8'h07, 64'h0,                 64'h307, 64'h0};
    vecs[3] = '{1'b0, 8'hFF, 64'hDEAD,              64'h0FF, 64'h0};
    vecs[4] = '{1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FF, 64'hFFFF_FFFF_FFFF_FFFF};

    rst_i = 1'b1; res_val_i = 1'b0; res_is_alloc_i = 1'b0;
    res_id_i = 8'd0; res_data_i = 64'd0; rsp_rdy_i = 1'b0;
    repeat (3) tick();
    check("rst_val",  {63'd0, rsp_val_o}, 64'd0);
    check("rst_data", rsp_data_o, 64'd0);
    check("rst_last", {63'd0, rsp_last_o}, 64'd0);
    check("rst_rdy",  {63'd0, res_rdy_o}, 64'd0);
    check("rst_occ",  {61'd0, occupancy_o}, 64'd0);
    rst_i = 1'b0;
    tick();
    check("rdy_after_reset", {63'd0, res_rdy_o}, 64'd1);

    // Single messages: header in the cycle after acceptance, then data for allocs.
    rsp_rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_one(vecs[i].is_alloc, vecs[i].id, vecs[i].addr);
      check("vec_hdr_val",  {63'd0, rsp_val_o}, 64'd1);
      check("vec_hdr",      rsp_data_o, vecs[i].exp_hdr);
      check("vec_hdr_last", {63'd0, rsp_last_o}, {63'd0, !vecs[i].is_alloc});
      check("vec_occ",      {61'd0, occupancy_o}, 64'd1);
      tick();
      if (vecs[i].is_alloc) begin
        check("vec_data_val",  {63'd0, rsp_val_o}, 64'd1);
        check("vec_data",      rsp_data_o, vecs[i].exp_data);
        check("vec_data_last", {63'd0, rsp_last_o}, 64'd1);
        tick();
      end
      check("vec_idle_val",  {63'd0, rsp_val_o}, 64'd0);
      check("vec_idle_data", rsp_data_o, 64'd0);
      check("vec_idle_last", {63'd0, rsp_last_o}, 64'd0);
    end

    // Fill with consumer stalled, fifth result waits for the first pop.
    rsp_rdy_i = 1'b0;
    push_one(1'b0, 8'h10, 64'h0);
    push_one(1'b1, 8'h11, 64'h2000);
    push_one(1'b0, 8'h12, 64'h0);
    push_one(1'b1, 8'h13, 64'h0);
    check("full_rdy", {63'd0, res_rdy_o}, 64'd0);
    check("full_occ", {61'd0, occupancy_o}, 64'd4);
    res_val_i = 1'b1; res_is_alloc_i = 1'b0; res_id_i = 8'h14; res_data_i = 64'd0;
    repeat (3) begin
      tick();
      check("stalled_occ", {61'd0, occupancy_o}, 64'd4);
      check("stalled_hdr", rsp_data_o, 64'h010);
    end
    rsp_rdy_i = 1'b1;
    begin
      int w;
      w = 0;
      while (!res_rdy_o && w < 20) begin
        tick();
        w++;
      end
      check("fifth_wait", 64'(w), 64'd1);
      tick();
      res_val_i = 1'b0;
    end
    drain("wrap_drain");

    // Back-to-back frees: one message per cycle.
    for (int k = 0; k < 8; k++) begin
      push_one(1'b0, 8'(8'h40 + k), 64'h0);
      res_val_i = 1'b1;
      check("tput_val",  {63'd0, rsp_val_o}, 64'd1);
      check("tput_hdr",  rsp_data_o, 64'(8'h40 + k));
      check("tput_last", {63'd0, rsp_last_o}, 64'd1);
    end
    res_val_i = 1'b0;
    tick();
    check("tput_end_val", {63'd0, rsp_val_o}, 64'd0);

    // Random mixed stream with a 50% consumer.
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int w;
          res_val_i      = 1'b1;
          res_is_alloc_i = 1'($urandom_range(0, 1));
          res_id_i       = 8'($urandom);
          res_data_i     = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
          w = 0;
          while (!res_rdy_o && w < 100) begin
            tick();
            w++;
          end
          if (w >= 100) check("rnd_accept_timeout", 64'(w), 64'd0);
          tick();
        end
        res_val_i = 1'b0;
        rnd_done  = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rsp_rdy_i = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain("rnd_drain");

    // Reset during a data beat with three results buffered.
    rsp_rdy_i = 1'b0;
    push_one(1'b1, 8'h21, 64'hAAAA);
    push_one(1'b0, 8'h22, 64'h0);
    push_one(1'b0, 8'h23, 64'h0);
    rsp_rdy_i = 1'b1;
    tick();
    rsp_rdy_i = 1'b0;
    check("pre_rst_data", rsp_data_o, 64'hAAAA);
    check("pre_rst_occ",  {61'd0, occupancy_o}, 64'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_val",  {63'd0, rsp_val_o}, 64'd0);
    check("mid_rst_data", rsp_data_o, 64'd0);
    check("mid_rst_last", {63'd0, rsp_last_o}, 64'd0);
    check("mid_rst_occ",  {61'd0, occupancy_o}, 64'd0);
    check("mid_rst_rdy",  {63'd0, res_rdy_o}, 64'd0);
    tick();
    check("post_rst_rdy", {63'd0, res_rdy_o}, 64'd1);
    rsp_rdy_i = 1'b1;
    push_one(1'b0, 8'h33, 64'h0);
    check("post_rst_val",  {63'd0, rsp_val_o}, 64'd1);
    check("post_rst_hdr",  rsp_data_o, 64'h033);
    check("post_rst_last", {63'd0, rsp_last_o}, 64'd1);
    tick();
    check("post_rst_idle", {63'd0, rsp_val_o}, 64'd0);
    check("post_rst_q",    64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
